// File: rtl/issue_unit_pkg.sv
// Shared opcode, register-index and state definitions for the issue stage.
// ISSUE_FWD_EN selects same-cycle writeback bypass of source operands.
package issue_unit_pkg;

    localparam int N_REG = 64;
    localparam int PC_W  = 14;
    localparam int IDX_W = 6;

    localparam logic [5:0] OPE_NOP  = 6'b000000;
    localparam logic [5:0] OPE_J    = 6'b000010;
    localparam logic [5:0] OPE_JAL  = 6'b000110;
    localparam logic [5:0] OPE_JR   = 6'b001010;
    localparam logic [5:0] OPE_JALR = 6'b001110;
    localparam logic [5:0] OPE_BEQ  = 6'b010010;
    localparam logic [5:0] OPE_BNE  = 6'b011010;
    localparam logic [5:0] OPE_BLT  = 6'b110010;
    localparam logic [5:0] OPE_BLE  = 6'b111010;
    localparam logic [5:0] OPE_BEQI = 6'b100010;
    localparam logic [5:0] OPE_BNEI = 6'b101010;

    localparam logic [IDX_W-1:0] LINK_REG = 6'd31;

    localparam logic [1:0] FPU_MASK  = 2'b11;
    localparam logic [1:0] FPU_CLASS = 2'b01;

    typedef enum logic [1:0] {
        RUN,
        BR_WAIT,
        BR_RES
    } state_t;

    function automatic logic is_branch(input logic [5:0] o);
        return o inside {OPE_BEQ, OPE_BNE, OPE_BLT,
                         OPE_BLE, OPE_BEQI, OPE_BNEI};
    endfunction

    function automatic logic is_jump(input logic [5:0] o);
        return o inside {OPE_J, OPE_JAL, OPE_JR, OPE_JALR};
    endfunction

    function automatic logic is_link(input logic [5:0] o);
        return o inside {OPE_JAL, OPE_JALR};
    endfunction

    function automatic logic is_direct(input logic [5:0] o);
        return o inside {OPE_J, OPE_JAL};
    endfunction

    function automatic logic is_fpu(input logic [5:0] o);
        return (o[1:0] & FPU_MASK) == FPU_CLASS;
    endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Decoder-to-issue instruction handshake bundle.
interface issue_unit_if;
    import issue_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc;
    logic [5:0]       in_ope;
    logic [IDX_W-1:0] in_ds;
    logic [IDX_W-1:0] in_dt;
    logic [IDX_W-1:0] in_dd;
    logic [15:0]      in_imm;
    logic [4:0]       in_opr;
    logic [3:0]       in_ctrl;

    modport master (
        output in_valid, in_pc, in_ope, in_ds, in_dt,
        output in_dd, in_imm, in_opr, in_ctrl,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_ope, in_ds, in_dt,
        input  in_dd, in_imm, in_opr, in_ctrl,
        output in_ready
    );

endinterface

// File: rtl/issue_unit_regfile.sv
// 2R/2W register file, FPU port wins on equal index, index 0 reads zero.
// Under ISSUE_FWD_EN the read ports bypass this cycle's writeback data.
import issue_unit_pkg::*;

module issue_unit_regfile #(
    parameter int NREG = N_REG
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] alu_addr,
    input  logic [31:0]      alu_val,
    input  logic [IDX_W-1:0] fpu_addr,
    input  logic [31:0]      fpu_val,
    input  logic [IDX_W-1:0] ra_s,
    input  logic [IDX_W-1:0] ra_t,
    output logic [31:0]      rd_s,
    output logic [31:0]      rd_t
);

    logic [31:0] mem [NREG];

    // FPU write is issued last so it overrides the ALU on a collision
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            if (alu_addr != '0) mem[alu_addr] <= alu_val;
            if (fpu_addr != '0) mem[fpu_addr] <= fpu_val;
        end
    end

    always_comb begin
        rd_s = mem[ra_s];
        rd_t = mem[ra_t];
`ifdef ISSUE_FWD_EN
        if (alu_addr == ra_s) rd_s = alu_val;
        if (fpu_addr == ra_s) rd_s = fpu_val;
        if (alu_addr == ra_t) rd_t = alu_val;
        if (fpu_addr == ra_t) rd_t = fpu_val;
`endif
        if (ra_s == '0) rd_s = '0;
        if (ra_t == '0) rd_t = '0;
    end

endmodule

// File: rtl/issue_unit.sv
// Register-read / issue stage feeding unit1 with scoreboard and redirect.
// Optional ISSUE_FWD_EN lets sources clear on this cycle's writeback.
import issue_unit_pkg::*;

module issue_unit #(
    parameter int NREG = N_REG,
    parameter int PCW  = PC_W
) (
    input  logic             clk,
    input  logic             rstn,
    issue_unit_if.slave      dec,
    input  logic [6:0]       is_busy,
    input  logic             b_is_hazard,
    input  logic [PCW-1:0]   b_addr,
    input  logic [IDX_W-1:0] alu_addr,
    input  logic [31:0]      alu_dd_val,
    input  logic [IDX_W-1:0] fpu_addr,
    input  logic [31:0]      fpu_dd_val,
    output logic [PCW-1:0]   pc,
    output logic [5:0]       ope,
    output logic [31:0]      ds_val,
    output logic [31:0]      dt_val,
    output logic [IDX_W-1:0] dd,
    output logic [15:0]      imm,
    output logic [4:0]       opr,
    output logic [3:0]       ctrl,
    output logic             redirect_valid,
    output logic [PCW-1:0]   redirect_pc
);

    state_t           state;
    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  pend_nxt;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic [IDX_W-1:0] eff_dd;
    logic             rs_ok;
    logic             rt_ok;
    logic             waw;
    logic             fpu_stall;
    logic             fire;

    issue_unit_regfile #(.NREG(NREG)) u_rf (
        .clk      (clk),
        .rstn     (rstn),
        .alu_addr (alu_addr),
        .alu_val  (alu_dd_val),
        .fpu_addr (fpu_addr),
        .fpu_val  (fpu_dd_val),
        .ra_s     (dec.in_ds),
        .ra_t     (dec.in_dt),
        .rd_s     (rs_val),
        .rd_t     (rt_val)
    );

`ifdef ISSUE_FWD_EN
    function automatic logic wb_hit(input logic [IDX_W-1:0] r);
        return (r != '0) && (alu_addr == r || fpu_addr == r);
    endfunction

    assign rs_ok = !pend[dec.in_ds] || wb_hit(dec.in_ds);
    assign rt_ok = !pend[dec.in_dt] || wb_hit(dec.in_dt);
`else
    assign rs_ok = !pend[dec.in_ds];
    assign rt_ok = !pend[dec.in_dt];
`endif

    assign eff_dd    = is_link(dec.in_ope) ? LINK_REG : dec.in_dd;
    assign waw       = pend[eff_dd];
    assign fpu_stall = is_fpu(dec.in_ope) && (|is_busy);

    assign dec.in_ready = rstn && (state == RUN) && !redirect_valid
                        && rs_ok && rt_ok && !waw && !fpu_stall;
    assign fire = dec.in_valid && dec.in_ready;

    // A new claim on an index outranks a writeback retiring it
    always_comb begin
        pend_nxt = pend;
        if (alu_addr != '0) pend_nxt[alu_addr] = 1'b0;
        if (fpu_addr != '0) pend_nxt[fpu_addr] = 1'b0;
        if (fire && eff_dd != '0) pend_nxt[eff_dd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pend <= '0;
        else       pend <= pend_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= RUN;
            pc             <= '0;
            ope            <= OPE_NOP;
            ds_val         <= '0;
            dt_val         <= '0;
            dd             <= '0;
            imm            <= '0;
            opr            <= '0;
            ctrl           <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (fire) begin
                pc     <= dec.in_pc;
                ope    <= dec.in_ope;
                ds_val <= rs_val;
                dt_val <= rt_val;
                dd     <= eff_dd;
                imm    <= dec.in_imm;
                opr    <= dec.in_opr;
                ctrl   <= dec.in_ctrl;
                if (is_jump(dec.in_ope)) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= is_direct(dec.in_ope)
                                    ? dec.in_imm[PCW-1:0]
                                    : rs_val[PCW-1:0];
                end
            end else begin
                ope <= OPE_NOP;
                dd  <= '0;
            end
            unique case (state)
                BR_WAIT: state <= BR_RES;
                BR_RES: begin
                    state <= RUN;
                    if (b_is_hazard) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= b_addr;
                    end
                end
                default: begin
                    if (fire && is_branch(dec.in_ope)) state <= BR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Directed self-checking bench for issue_unit (default and ISSUE_FWD_EN builds).
module tb_issue_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  is_busy = '0;
    logic        b_is_hazard = 1'b0;
    logic [13:0] b_addr = '0;
    logic [5:0]  alu_addr = '0;
    logic [31:0] alu_dd_val = '0;
    logic [5:0]  fpu_addr = '0;
    logic [31:0] fpu_dd_val = '0;
    logic [13:0] pc;
    logic [5:0]  ope;
    logic [31:0] ds_val;
    logic [31:0] dt_val;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [4:0]  opr;
    logic [3:0]  ctrl;
    logic        redirect_valid;
    logic [13:0] redirect_pc;

    int n_chk  = 0;
    int n_fail = 0;

    issue_unit_if dec();

    issue_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .dec            (dec.slave),
        .is_busy        (is_busy),
        .b_is_hazard    (b_is_hazard),
        .b_addr         (b_addr),
        .alu_addr       (alu_addr),
        .alu_dd_val     (alu_dd_val),
        .fpu_addr       (fpu_addr),
        .fpu_dd_val     (fpu_dd_val),
        .pc             (pc),
        .ope            (ope),
        .ds_val         (ds_val),
        .dt_val         (dt_val),
        .dd             (dd),
        .imm            (imm),
        .opr            (opr),
        .ctrl           (ctrl),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [13:0] p,
                       input logic [5:0] o, input logic [5:0] s,
                       input logic [5:0] t, input logic [5:0] d,
                       input logic [15:0] i);
        dec.in_valid = v;
        dec.in_pc    = p;
        dec.in_ope   = o;
        dec.in_ds    = s;
        dec.in_dt    = t;
        dec.in_dd    = d;
        dec.in_imm   = i;
        dec.in_opr   = 5'd7;
        dec.in_ctrl  = 4'hA;
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_ope", ope, 0);
        chk("rst_pc", pc, 0);
        chk("rst_redir", redirect_valid, 0);
        chk("rst_ready", dec.in_ready, 0);
        tick();
        rstn = 1'b1;

        // ADDI r3 = r0 + 5
        drv(1, 14'h1, 6'b001000, 0, 0, 3, 16'd5);
        chk("addi_ready", dec.in_ready, 1);
        tick();
        chk("addi_ope", ope, 6'b001000);
        chk("addi_dsval", ds_val, 0);
        chk("addi_dd", dd, 3);
        chk("addi_opr", opr, 7);

        // dependent ADD reads r3
        drv(1, 14'h2, 6'b100000, 3, 0, 6, 16'd0);
        chk("raw_hold", dec.in_ready, 0);
        alu_addr = 3; alu_dd_val = 5; #1;
`ifdef ISSUE_FWD_EN
        chk("fwd_ready", dec.in_ready, 1);
        tick();
        alu_addr = 0;
`else
        chk("raw_ready", dec.in_ready, 0);
        tick();
        alu_addr = 0; #1;
        chk("raw_nop", ope, 0);
        chk("raw_ready2", dec.in_ready, 1);
        tick();
`endif
        chk("raw_ope", ope, 6'b100000);
        chk("raw_dsval", ds_val, 5);
        chk("raw_dd", dd, 6);

        // retire r6, then JAL
        drv(0, 0, 0, 0, 0, 0, 0);
        alu_addr = 6; alu_dd_val = 32'h66;
        tick();
        alu_addr = 0;
        drv(1, 14'h10, 6'b000110, 0, 0, 0, 16'h0123);
        chk("jal_ready", dec.in_ready, 1);
        tick();
        chk("jal_redir", redirect_valid, 1);
        chk("jal_rpc", redirect_pc, 14'h0123);
        chk("jal_dd", dd, 31);
        chk("jal_pc", pc, 14'h10);
        drv(1, 14'h11, 6'b100000, 0, 0, 7, 16'd0);
        chk("jal_block", dec.in_ready, 0);
        tick();
        chk("jal_pulse", redirect_valid, 0);
        chk("jal_nop", ope, 0);
        chk("jal_after", dec.in_ready, 1);
        tick();
        chk("post_ope", ope, 6'b100000);
        chk("post_dd", dd, 7);

        // r31 still pending: JALR must stall on WAW
        drv(1, 14'h12, 6'b001110, 0, 0, 0, 16'd0);
        chk("waw_hold", dec.in_ready, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        alu_addr = 31; alu_dd_val = 32'h11;
        fpu_addr = 7;  fpu_dd_val = 32'h77;
        tick();
        alu_addr = 0; fpu_addr = 0;

        // taken branch
        drv(1, 14'h20, 6'b110010, 0, 0, 0, 16'd0);
        tick();
        chk("br_issue", ope, 6'b110010);
        drv(1, 14'h21, 6'b100000, 0, 0, 0, 16'd0);
        chk("br_wait_rdy", dec.in_ready, 0);
        tick();
        chk("br_nop", ope, 0);
        chk("br_res_rdy", dec.in_ready, 0);
        b_is_hazard = 1; b_addr = 14'h0200;
        tick();
        b_is_hazard = 0;
        chk("br_redir", redirect_valid, 1);
        chk("br_rpc", redirect_pc, 14'h0200);
        chk("br_e2_ope", ope, 0);
        tick();
        chk("br_pulse", redirect_valid, 0);
        chk("br_rdy", dec.in_ready, 1);

        // not-taken branch
        drv(1, 14'h30, 6'b010010, 0, 0, 0, 16'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        b_is_hazard = 0; b_addr = 14'h0300;
        chk("nt_res_rdy", dec.in_ready, 0);
        tick();
        chk("nt_redir", redirect_valid, 0);
        chk("nt_rdy", dec.in_ready, 1);

        // FPU busy interlock
        is_busy = 7'b0000100;
        drv(1, 14'h40, 6'b000001, 0, 0, 10, 16'd0);
        chk("fpu_busy", dec.in_ready, 0);
        drv(1, 14'h41, 6'b100000, 0, 0, 11, 16'd0);
        chk("int_rdy", dec.in_ready, 1);
        tick();
        chk("int_dd", dd, 11);
        drv(1, 14'h40, 6'b000001, 0, 0, 10, 16'd0);
        tick();
        chk("fpu_hold", ope, 0);
        is_busy = 0; #1;
        chk("fpu_free", dec.in_ready, 1);
        tick();
        chk("fpu_ope", ope, 6'b000001);
        chk("fpu_dd", dd, 10);

        // same-index writeback: FPU wins
        drv(0, 0, 0, 0, 0, 0, 0);
        alu_addr = 9; alu_dd_val = 1;
        fpu_addr = 9; fpu_dd_val = 2;
        tick();
        alu_addr = 0; fpu_addr = 0;
        drv(1, 14'h50, 6'b100000, 9, 3, 0, 16'd0);
        tick();
        chk("dual_wr", ds_val, 2);
        chk("rf_r3", dt_val, 5);

        // JR through r3
        drv(1, 14'h51, 6'b001010, 3, 0, 0, 16'h3FFF);
        tick();
        chk("jr_redir", redirect_valid, 1);
        chk("jr_rpc", redirect_pc, 14'h5);
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        // reset while resolving a branch
        drv(1, 14'h60, 6'b111010, 0, 0, 0, 16'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        b_is_hazard = 1; b_addr = 14'h3FF;
        rstn = 0; #1;
        chk("mid_ope", ope, 0);
        chk("mid_pc", pc, 0);
        chk("mid_redir", redirect_valid, 0);
        tick();
        rstn = 1;
        tick();
        b_is_hazard = 0;
        chk("mid_noredir", redirect_valid, 0);
        drv(1, 14'h70, 6'b100000, 3, 0, 0, 16'd0);
        chk("mid_rdy", dec.in_ready, 1);
        tick();
        chk("mid_rf_clr", ds_val, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
